// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle ALU: add, subtract, iterative multiply, iterative divide
//
// Purpose:
//   Accepts one operation at a time over a valid/ready handshake and returns a
//   registered 2*WIDTH_P-bit result over a second valid/ready handshake.
//   Add/Sub finish in one cycle. Mul (shift-add) and Div (restoring) use one
//   datapath step per cycle for WIDTH_P cycles. The result is held until the
//   next result is written.
//
// Configuration:
//   ALU_ITER_DIV_EN - when defined, the divider is built and opcode 4 is Div.
//                     When undefined, opcode 4 is illegal and div0_o is tied to 0.
//
// Ports:
//   clk_i        in   clock, all logic on the rising edge
//   reset_i      in   synchronous active-high reset
//   valid_i      in   request valid
//   opcode_i     in   0 Nop, 1 Add, 2 Sub, 3 Mul, 4 Div, 5-7 illegal
//   operand_a_i  in   operand A (dividend for Div)
//   operand_b_i  in   operand B (divisor for Div)
//   ready_o      out  ALU can accept a request (idle)
//   ready_i      in   downstream can take the result
//   result_o     out  registered result
//   div0_o       out  result_o came from a divide by zero
//   valid_o      out  result_o/div0_o valid
module alu_iter #(
  parameter int unsigned WIDTH_P = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic [2:0]             opcode_i,
  input  logic [WIDTH_P-1:0]     operand_a_i,
  input  logic [WIDTH_P-1:0]     operand_b_i,
  output logic                   ready_o,
  input  logic                   ready_i,
  output logic [2*WIDTH_P-1:0]   result_o,
  output logic                   div0_o,
  output logic                   valid_o
);

  localparam int unsigned CntW = $clog2(WIDTH_P) + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH_P - 1);

  // Opcode 0 (Nop) and 5-7 fall through every decode below and are simply consumed.
  localparam logic [2:0] OpAdd = 3'd1;
  localparam logic [2:0] OpSub = 3'd2;
  localparam logic [2:0] OpMul = 3'd3;
`ifdef ALU_ITER_DIV_EN
  localparam logic [2:0] OpDiv = 3'd4;
`endif

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                   accept;
  logic                   is_add, is_sub, is_mul;
  logic [WIDTH_P:0]       add_sum, sub_diff;

  // p_q is the shared iterative register: {partial product, multiplier} for Mul,
  // {partial remainder, dividend/quotient} for Div. opnd_q holds the operand
  // that stays fixed during iteration (multiplicand or divisor).
  logic [2*WIDTH_P-1:0]   p_q, p_step;
  logic [WIDTH_P-1:0]     opnd_q;
  logic [CntW-1:0]        cnt_q;
  logic [2*WIDTH_P-1:0]   result_q;
  logic                   div0_q;

  logic [WIDTH_P-1:0]     mul_addend;
  logic [WIDTH_P:0]       mul_sum;
  logic [2*WIDTH_P-1:0]   mul_step;

  assign accept = valid_i & ready_o;
  assign is_add = (opcode_i == OpAdd);
  assign is_sub = (opcode_i == OpSub);
  assign is_mul = (opcode_i == OpMul);

  // The top bit of sub_diff is the borrow, since both operands are zero-extended.
  assign add_sum  = {1'b0, operand_a_i} + {1'b0, operand_b_i};
  assign sub_diff = {1'b0, operand_a_i} - {1'b0, operand_b_i};

  // Shift-add: conditionally add the multiplicand into the upper half, then shift
  // the whole register right so the next multiplier bit lands in bit 0.
  assign mul_addend = p_q[0] ? opnd_q : '0;
  assign mul_sum    = {1'b0, p_q[2*WIDTH_P-1:WIDTH_P]} + {1'b0, mul_addend};
  assign mul_step   = {mul_sum, p_q[WIDTH_P-1:1]};

`ifdef ALU_ITER_DIV_EN
  logic                   is_div, div_by_zero, div_mode_q;
  logic [WIDTH_P:0]       div_diff;
  logic [2*WIDTH_P-1:0]   div_step;

  assign is_div      = (opcode_i == OpDiv);
  assign div_by_zero = (operand_b_i == '0);

  // Restoring step on {remainder, next dividend bit}. The partial remainder is
  // always below the divisor, so the shifted value is below 2*divisor and the
  // top bit of a (WIDTH_P+1)-bit difference is exactly the borrow.
  assign div_diff = p_q[2*WIDTH_P-1:WIDTH_P-1] - {1'b0, opnd_q};
  assign div_step = div_diff[WIDTH_P] ? {p_q[2*WIDTH_P-2:0], 1'b0}
                                      : {div_diff[WIDTH_P-1:0], p_q[WIDTH_P-2:0], 1'b1};
  assign p_step   = div_mode_q ? div_step : mul_step;
`else
  assign p_step   = mul_step;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (is_add || is_sub) begin
            state_d = StDone;
          end else if (is_mul) begin
            state_d = StBusy;
          end
`ifdef ALU_ITER_DIV_EN
          else if (is_div) begin
            state_d = div_by_zero ? StDone : StBusy;
          end
`endif
        end
      end
      StBusy: begin
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p_q        <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div0_q     <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      div_mode_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q <= '0;
            if (is_add) begin
              result_q <= {{WIDTH_P{add_sum[WIDTH_P]}}, add_sum[WIDTH_P-1:0]};
              div0_q   <= 1'b0;
            end else if (is_sub) begin
              result_q <= {{WIDTH_P{sub_diff[WIDTH_P]}}, sub_diff[WIDTH_P-1:0]};
              div0_q   <= 1'b0;
            end else if (is_mul) begin
              opnd_q     <= operand_a_i;
              p_q        <= {{WIDTH_P{1'b0}}, operand_b_i};
`ifdef ALU_ITER_DIV_EN
              div_mode_q <= 1'b0;
`endif
            end
`ifdef ALU_ITER_DIV_EN
            else if (is_div) begin
              if (div_by_zero) begin
                result_q <= {operand_a_i, {WIDTH_P{1'b1}}};
                div0_q   <= 1'b1;
              end else begin
                opnd_q     <= operand_b_i;
                p_q        <= {{WIDTH_P{1'b0}}, operand_a_i};
                div_mode_q <= 1'b1;
              end
            end
`endif
          end
        end
        StBusy: begin
          p_q   <= p_step;
          cnt_q <= cnt_q + CntW'(1);
          // The final step is written straight into the result register so the
          // answer is visible on the same edge the FSM enters StDone.
          if (cnt_q == LastIter) begin
            result_q <= p_step;
            div0_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;
  assign div0_o   = div0_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - self-checking bench for alu_iter at WIDTH_P=32
module tb_alu_iter;

  localparam int W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_i;
  logic [2:0]      opcode_i;
  logic [W-1:0]    operand_a_i;
  logic [W-1:0]    operand_b_i;
  logic            ready_o;
  logic            ready_i;
  logic [2*W-1:0]  result_o;
  logic            div0_o;
  logic            valid_o;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH_P(W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .valid_i     (valid_i),
    .opcode_i    (opcode_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .ready_o     (ready_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .div0_o      (div0_o),
    .valid_o     (valid_o)
  );

  // Reference model: what the result and latency of an accepted operation must be.
  function automatic logic [2*W:0] model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    case (op)
      3'd1: begin
        s = {1'b0, a} + {1'b0, b};
        return {1'b0, {W{s[W]}}, s[W-1:0]};
      end
      3'd2: return {1'b0, (a < b) ? {W{1'b1}} : {W{1'b0}}, a - b};
      3'd3: return {1'b0, 64'(a) * 64'(b)};
`ifdef ALU_ITER_DIV_EN
      3'd4: begin
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        return {1'b0, a % b, a / b};
      end
`endif
      default: return '0;
    endcase
  endfunction

  // 0 means the request is consumed with no result.
  function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] b);
    case (op)
      3'd1, 3'd2: return 1;
      3'd3: return W + 1;
`ifdef ALU_ITER_DIV_EN
      3'd4: return (b == 0) ? 1 : W + 1;
`endif
      default: return 0;
    endcase
  endfunction

  logic           m_valid;
  logic [2*W-1:0] m_res, pend_res;
  logic           m_div0, pend_div0;
  int             m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_div0  <= 1'b0;
      m_left  <= 0;
    end else if (m_valid) begin
      if (ready_i) m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_res   <= pend_res;
        m_div0  <= pend_div0;
      end
    end else if (valid_i) begin
      if (model_lat(opcode_i, operand_b_i) == 1) begin
        m_valid <= 1'b1;
        {m_div0, m_res} <= model_op(opcode_i, operand_a_i, operand_b_i);
      end else if (model_lat(opcode_i, operand_b_i) > 1) begin
        m_left <= model_lat(opcode_i, operand_b_i) - 1;
        {pend_div0, pend_res} <= model_op(opcode_i, operand_a_i, operand_b_i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (ready_o !== (!m_valid && m_left == 0) || valid_o !== m_valid ||
          result_o !== m_res || div0_o !== m_div0) begin
        n_fail++;
        $display("FAIL model t=%0t: dut rdy=%b vld=%b res=%h d0=%b, need rdy=%b vld=%b res=%h d0=%b",
                 $time, ready_o, valid_o, result_o, div0_o,
                 (!m_valid && m_left == 0), m_valid, m_res, m_div0);
      end
    end
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation, measure latency, optionally stall ready_i in StDone.
  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                        input logic exp_div0, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    valid_i = 1'b1; opcode_i = op; operand_a_i = a; operand_b_i = b;
    ready_i = (hold == 0);
    @(negedge clk);
    valid_i = 1'b0; opcode_i = 3'($urandom); operand_a_i = $urandom; operand_b_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, result_o, exp_res);
    check({name, "_div0"}, 64'(div0_o), 64'(exp_div0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(valid_o), 64'd1);
      check({name, "_hold_ready"}, 64'(ready_o), 64'd0);
      check({name, "_hold_result"}, result_o, exp_res);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check({name, "_after_valid"}, 64'(valid_o), 64'd0);
    check({name, "_after_ready"}, 64'(ready_o), 64'd1);
  endtask

  // Nop/illegal opcode: consumed at once, no result, result_o unchanged.
  task automatic run_nop(input string name, input logic [2:0] op, input logic [2*W-1:0] keep);
    @(negedge clk);
    valid_i = 1'b1; opcode_i = op; operand_a_i = 32'h1234_5678; operand_b_i = 32'd0;
    @(negedge clk);
    valid_i = 1'b0;
    check({name, "_ready"}, 64'(ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check({name, "_valid"}, 64'(valid_o), 64'd0);
      check({name, "_result"}, result_o, keep);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; opcode_i = '0; operand_a_i = '0; operand_b_i = '0; ready_i = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_div0", 64'(div0_o), 64'd0);
    reset = 1'b0;

    run_op("add_carry", 3'd1, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_0000_0000, 1'b0, 1, 0);
    run_op("add_small", 3'd1, 32'd5, 32'd7, 64'h0000_0000_0000_000C, 1'b0, 1, 0);
    run_op("sub_borrow", 3'd2, 32'd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 0);
    run_op("sub_plain", 3'd2, 32'd10, 32'd3, 64'h0000_0000_0000_0007, 1'b0, 1, 0);
    run_op("sub_equal", 3'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 64'h0, 1'b0, 1, 0);
    run_op("mul_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 33, 0);
    run_op("mul_shift", 3'd3, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 1'b0, 33, 0);
    run_op("mul_zero", 3'd3, 32'hABCD_0123, 32'd0, 64'h0, 1'b0, 33, 0);
    run_op("mul_hold", 3'd3, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 33, 5);
`ifdef ALU_ITER_DIV_EN
    run_op("div_basic", 3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33, 0);
    run_op("div_by0", 3'd4, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF}, 1'b1, 1, 0);
    run_op("div_max", 3'd4, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 33, 0);
    run_op("div_small", 3'd4, 32'd3, 32'd10, {32'd3, 32'd0}, 1'b0, 33, 0);
`endif
    run_op("add_last", 3'd1, 32'd1, 32'd1, 64'h0000_0000_0000_0002, 1'b0, 1, 0);

    run_nop("nop0", 3'd0, 64'h2);
    run_nop("ill5", 3'd5, 64'h2);
    run_nop("ill7", 3'd7, 64'h2);
`ifndef ALU_ITER_DIV_EN
    run_nop("ill4", 3'd4, 64'h2);
`endif

    // Reset in the middle of a multiply aborts it.
    @(negedge clk);
    valid_i = 1'b1; opcode_i = 3'd3; operand_a_i = 32'd7; operand_b_i = 32'd9;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_ready", 64'(ready_o), 64'd0);
    check("busy_valid", 64'(valid_o), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_ready", 64'(ready_o), 64'd1);
    check("abort_result", result_o, 64'd0);
    repeat (40) @(negedge clk);
    check("abort_no_result", 64'(valid_o), 64'd0);

    run_op("add_recover", 3'd1, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, 1, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
